// File: rtl/lb_ctrl_pkg.sv
// Shared state encoding and default widths for the loopback test sequencer.
package lb_ctrl_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_LEN_W       = 16;
    localparam int DEF_ERR_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_RX = 2'd2,
        DONE    = 2'd3
    } lb_state_e;

endpackage

// File: rtl/lb_pattern_cnt.sv
// Wrapping DATA_W pattern counter; clr has priority over en.
import lb_ctrl_pkg::*;

module lb_pattern_cnt #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic [DATA_W-1:0] cnt
);

    logic [DATA_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/loopback_seq_ctrl.sv
// Loopback test sequencer: sends a wrapping counter burst and checks the looped-back stream.
// Define LB_TIMEOUT_EN to add the WAIT_RX watchdog and the timeout flag.
import lb_ctrl_pkg::*;

module loopback_seq_ctrl #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int ERR_W       = DEF_ERR_W
`ifdef LB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              timeout
);

    lb_state_e          state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   sent_q, sent_d;
    logic [LEN_W-1:0]   rcvd_q, rcvd_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [DATA_W-1:0]  tx_cnt, exp_cnt;
    logic               start_ok, tx_en, exp_en, rx_active;

`ifdef LB_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
`endif

    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign rx_active = (state_q == SEND) || (state_q == WAIT_RX);
    assign tx_en     = (state_q == SEND) && tx_ready;
    assign exp_en    = rx_active && rx_valid && (rcvd_q < len_q);

    lb_pattern_cnt #(.DATA_W(DATA_W)) u_tx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tx_en),
        .clr   (start_ok),
        .cnt   (tx_cnt)
    );

    lb_pattern_cnt #(.DATA_W(DATA_W)) u_exp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (exp_en),
        .clr   (start_ok),
        .cnt   (exp_cnt)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sent_d  = sent_q;
        rcvd_d  = rcvd_q;
        err_d   = err_q;
`ifdef LB_TIMEOUT_EN
        timeout_d = timeout_q;
        wdog_d    = '0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d   = burst_len;
                    sent_d  = '0;
                    rcvd_d  = '0;
                    err_d   = '0;
`ifdef LB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = (burst_len != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    sent_d = sent_q + LEN_W'(1);
                    if (sent_q == len_q - LEN_W'(1)) begin
                        state_d = WAIT_RX;
                    end
                end
            end
            WAIT_RX: begin
                if (rcvd_q == len_q) begin
                    state_d = DONE;
`ifdef LB_TIMEOUT_EN
                end else if (!rx_valid) begin
                    if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Beats past the burst length are overruns and count as errors without advancing the check.
        if (rx_active && rx_valid) begin
            if (rcvd_q < len_q) begin
                rcvd_d = rcvd_q + LEN_W'(1);
                if ((rx_data != exp_cnt) && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
            end else if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            sent_q  <= '0;
            rcvd_q  <= '0;
            err_q   <= '0;
`ifdef LB_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            rcvd_q  <= rcvd_d;
            err_q   <= err_d;
`ifdef LB_TIMEOUT_EN
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

`ifdef LB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign tx_data   = tx_cnt;
    assign tx_valid  = (state_q == SEND);
    assign busy      = rx_active;
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == '0) && !timeout;
    assign err_count = err_q;

endmodule

// File: tb/tb_loopback_seq_ctrl.sv
// Self-checking bench for loopback_seq_ctrl: acts as TX sink and RX loopback source,
// predicting beats, error count and pass/timeout from the burst rules.
`timescale 1ns/1ps

module tb_loopback_seq_ctrl;

    localparam int NONE = -1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] burst_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic        timeout;

    int nChecks = 0;
    int nFails  = 0;

    loopback_seq_ctrl #(
        .DATA_W      (8),
        .LEN_W       (16),
        .ERR_W       (16)
`ifdef LB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
        checkOutput({tag, "_tx_data"}, {24'd0, tx_data}, 0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
        checkOutput({tag, "_done"}, {31'd0, done}, 0);
        checkOutput({tag, "_pass"}, {31'd0, pass}, 0);
        checkOutput({tag, "_err_count"}, {16'd0, err_count}, 0);
        checkOutput({tag, "_timeout"}, {31'd0, timeout}, 0);
    endtask

    // One burst: TX beats looped back 3 cycles later, optional corruption, overrun beat,
    // truncated RX stream, mid-burst reset and ignored start pulses while busy.
    task automatic applyStimulus(input int len, input int readyMode, input int corruptIdx,
                                 input logic [7:0] corruptVal, input int extraBeats,
                                 input int rxLimit, input int resetAtBeat, input bit noiseStart);
        int         txCount = 0;
        int         rxCount = 0;
        int         expErr = 0;
        int         doneCyc = 0;
        int         lastRxCyc = 0;
        int         bound;
        bit         finished = 0;
        bit         expTimeout;
        int         rxDueQ[$];
        logic [7:0] rxValQ[$];
        logic [7:0] val;

`ifdef LB_TIMEOUT_EN
        expTimeout = (rxLimit >= 0) && (rxLimit < len);
`else
        expTimeout = 0;
`endif
        bound = 4 * len + 200;
        for (int c = 0; c < bound && !finished; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start     = 1'b1;
                burst_len = 16'(len);
                tx_ready  = 1'b0;
                rx_valid  = 1'b0;
                continue;
            end
            if (done) begin
                finished = 1;
                doneCyc  = c;
                start    = 1'b0;
                rx_valid = 1'b0;
                break;
            end
            if (resetAtBeat >= 0 && txCount == resetAtBeat) begin
                rst_n    = 1'b0;
                start    = 1'b0;
                rx_valid = 1'b0;
                tx_ready = 1'b0;
                @(negedge clk);
                checkIdleOutputs("mid_reset");
                rst_n = 1'b1;
                return;
            end
            start = noiseStart && ($urandom_range(0, 7) == 0);
            if (start) burst_len = 16'($urandom_range(1, 50));

            if (tx_valid) begin
                checkOutput("tx_data", {24'd0, tx_data}, {24'd0, 8'(txCount)});
                checkOutput("busy_in_send", {31'd0, busy}, 1);
                tx_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (tx_ready) begin
                    val = (txCount == corruptIdx) ? corruptVal : 8'(txCount);
                    rxDueQ.push_back(c + 3);
                    rxValQ.push_back(val);
                    txCount++;
                    if (txCount == len && extraBeats > 0) begin
                        rxDueQ.push_back(c + 4);
                        rxValQ.push_back(8'h5A);
                    end
                end
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end

            if (rxDueQ.size() > 0 && rxDueQ[0] == c) begin
                val = rxValQ[0];
                void'(rxDueQ.pop_front());
                void'(rxValQ.pop_front());
                if (rxLimit < 0 || rxCount < rxLimit) begin
                    rx_valid = 1'b1;
                    rx_data  = val;
                    if (rxCount >= len || val != 8'(rxCount)) expErr++;
                    rxCount++;
                    lastRxCyc = c;
                end else begin
                    rx_valid = 1'b0;
                end
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end

        checkOutput("done_within_bound", {31'd0, finished}, 1);
        checkOutput("tx_beats", txCount, len);
        checkOutput("err_count", {16'd0, err_count}, (expErr > 65535) ? 65535 : expErr);
        checkOutput("pass", {31'd0, pass}, {31'd0, (expErr == 0) && !expTimeout});
        checkOutput("timeout", {31'd0, timeout}, {31'd0, expTimeout});
        checkOutput("busy_in_done", {31'd0, busy}, 0);
        checkOutput("tx_valid_in_done", {31'd0, tx_valid}, 0);
        if (len == 0) checkOutput("len0_latency", doneCyc, 1);
        if (expTimeout) checkOutput("wdog_latency", doneCyc - lastRxCyc, 17);

        // RX traffic after completion must not disturb the result.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("done_hold", {31'd0, done}, 1);
        checkOutput("err_hold", {16'd0, err_count}, (expErr > 65535) ? 65535 : expErr);
    endtask

    initial begin
        int len;
        int cidx;
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] basic burst len=4");
        applyStimulus(4, 0, NONE, 8'h00, 0, NONE, NONE, 0);
        $display("[TB] len=300 with backpressure and wrap");
        applyStimulus(300, 1, NONE, 8'h00, 0, NONE, NONE, 1);
        $display("[TB] corrupted beat 5");
        applyStimulus(8, 0, 5, 8'hAA, 0, NONE, NONE, 0);
        $display("[TB] overrun beat and zero-length burst");
        applyStimulus(4, 0, NONE, 8'h00, 1, NONE, NONE, 0);
        applyStimulus(0, 0, NONE, 8'h00, 0, NONE, NONE, 0);
        $display("[TB] reset mid-burst then restart");
        applyStimulus(10, 0, NONE, 8'h00, 0, NONE, 3, 0);
        applyStimulus(2, 0, NONE, 8'h00, 0, NONE, NONE, 0);

        $display("[TB] randomized bursts");
        for (int i = 0; i < 8; i++) begin
            len  = $urandom_range(1, 40);
            cidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : NONE;
            applyStimulus(len, 1, cidx, 8'($urandom), $urandom_range(0, 1), NONE, NONE, 1);
        end

`ifdef LB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        applyStimulus(4, 0, NONE, 8'h00, 0, 2, NONE, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
